// File: rtl/au_sat_stage_pkg.sv
// rtl/au_sat_stage_pkg.sv - opcodes, saturation constants and flag positions for the AU saturation stage
package au_sat_stage_pkg;

  localparam int DW_FIXED = 16;

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_PADD = 4'b0000;

  localparam logic [15:0] SAT_POS16 = 16'h7FFF;
  localparam logic [15:0] SAT_NEG16 = 16'h8000;
  localparam logic [7:0]  SAT_POS8  = 8'h7F;
  localparam logic [7:0]  SAT_NEG8  = 8'h80;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  // Two same-signed operands producing an opposite-signed sum.
  function automatic logic sign_ovf(input logic sa, input logic sb, input logic ss);
    return (~sa & ~sb & ss) | (sa & sb & ~ss);
  endfunction

endpackage

// File: rtl/au_sat_stage_if.sv
// rtl/au_sat_stage_if.sv - AU-side input handshake and EX/MEM-side output slot of the saturation stage
interface au_sat_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cmd;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] sum;
  logic          cout;
  logic [RW-1:0] dst_in;
  logic          wr_en_in;
  logic          flag_we;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_dst;
  logic          out_wr_en;
  logic          out_cout;

  modport slave (
    input  in_valid, cmd, a, b, sum, cout, dst_in, wr_en_in, flag_we, out_ready,
    output in_ready, out_valid, out_result, out_dst, out_wr_en, out_cout
  );

  modport master (
    output in_valid, cmd, a, b, sum, cout, dst_in, wr_en_in, flag_we, out_ready,
    input  in_ready, out_valid, out_result, out_dst, out_wr_en, out_cout
  );
endinterface

// File: rtl/au_saturate.sv
// rtl/au_saturate.sv - combinational signed saturation of the raw AU sum (16-bit ADD/SUB, per-byte PADD)
module au_saturate
  import au_sat_stage_pkg::*;
(
  input  logic [3:0]  cmd,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] sum,
  output logic [15:0] sat_result,
  output logic        v16,
  output logic        v_hi,
  output logic        v_lo
);

  logic is_add;
  logic is_sub;
  logic is_padd;
  logic be_msb;

  // Only the sign bits of the operands take part in overflow detection.
  wire unused_ab = ^{a[14:8], a[6:0], b[14:8], b[6:0]};

  always_comb begin
    is_add  = (cmd == OP_ADD);
    is_sub  = (cmd == OP_SUB);
    is_padd = (cmd == OP_PADD);
    be_msb  = is_sub ? ~b[15] : b[15];

    v16  = (is_add | is_sub) & sign_ovf(a[15], be_msb, sum[15]);
    v_hi = is_padd & sign_ovf(a[15], b[15], sum[15]);
    v_lo = is_padd & sign_ovf(a[7], b[7], sum[7]);

    // A wrapped-negative sum means positive overflow, hence the inverted pick.
    sat_result = sum;
    if (v16)
      sat_result = sum[15] ? SAT_POS16 : SAT_NEG16;
    if (v_hi)
      sat_result[15:8] = sum[15] ? SAT_POS8 : SAT_NEG8;
    if (v_lo)
      sat_result[7:0] = sum[7] ? SAT_POS8 : SAT_NEG8;
  end

endmodule

// File: rtl/au_sat_stage.sv
// rtl/au_sat_stage.sv - EX/MEM slot with saturation and Z/V/N flags; AU_SAT_STICKY_EN enables the sticky saturation bit
module au_sat_stage
  import au_sat_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  au_sat_stage_if.slave bus,
  input  logic         flush,
  input  logic         sticky_clr,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_n,
  output logic         sat_sticky
);

  logic          in_ready;
  logic          capture;
  logic          is_addsub;
  logic [DW-1:0] sat_result;
  logic          v16;
  logic          v_hi;
  logic          v_lo;

  logic          valid_q;
  logic [DW-1:0] result_q;
  logic [RW-1:0] dst_q;
  logic          wr_q;
  logic          cout_q;
  logic [2:0]    flags_q;

  au_saturate u_saturate (
    .cmd        (bus.cmd),
    .a          (bus.a),
    .b          (bus.b),
    .sum        (bus.sum),
    .sat_result (sat_result),
    .v16        (v16),
    .v_hi       (v_hi),
    .v_lo       (v_lo)
  );

  assign in_ready     = ~valid_q | bus.out_ready;
  assign capture      = bus.in_valid & in_ready & ~flush;
  assign is_addsub    = (bus.cmd == OP_ADD) | (bus.cmd == OP_SUB);
  assign bus.in_ready = in_ready;

  // Flush kills the slot even while MEM is stalling it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      dst_q    <= '0;
      wr_q     <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (capture)
        valid_q <= 1'b1;
      else if (bus.out_ready)
        valid_q <= 1'b0;

      if (capture) begin
        result_q <= sat_result;
        dst_q    <= bus.dst_in;
        wr_q     <= bus.wr_en_in;
        cout_q   <= bus.cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (capture & bus.flag_we & is_addsub) begin
      flags_q[FLAG_Z] <= (sat_result == '0);
      flags_q[FLAG_V] <= v16;
      flags_q[FLAG_N] <= sat_result[DW-1];
    end
  end

`ifdef AU_SAT_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_q <= 1'b0;
    else if (capture & (v16 | v_hi | v_lo))
      sticky_q <= 1'b1;
    else if (sticky_clr)
      sticky_q <= 1'b0;
  end

  assign sat_sticky = sticky_q;
`else
  wire unused_sticky = ^{sticky_clr, v_hi, v_lo};

  assign sat_sticky = 1'b0;
`endif

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_dst    = dst_q;
  assign bus.out_wr_en  = wr_q & valid_q;
  assign bus.out_cout   = cout_q;
  assign flag_z         = flags_q[FLAG_Z];
  assign flag_v         = flags_q[FLAG_V];
  assign flag_n         = flags_q[FLAG_N];

endmodule

// File: tb/tb_au_sat_stage.sv
// tb/tb_au_sat_stage.sv - scoreboard bench for au_sat_stage, clamped-integer reference model
module tb_au_sat_stage;
  import au_sat_stage_pkg::*;

  typedef struct packed {
    logic        sat;
    logic [15:0] res;
  } mres_t;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  dst;
    logic        wr;
    logic        cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic sticky_clr = 1'b0;
  logic flag_z, flag_v, flag_n, sat_sticky;

  au_sat_stage_if #(.DW(16), .RW(4)) ifc ();

  au_sat_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .flush      (flush),
    .sticky_clr (sticky_clr),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  logic m_valid = 1'b0;
  logic [2:0] m_flags = 3'b000;
  logic m_sticky = 1'b0;
  logic rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gen_sum(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [7:0] hi, lo;
    hi = a[15:8] + b[15:8];
    lo = a[7:0] + b[7:0];
    if (c == OP_ADD) return a + b;
    if (c == OP_SUB) return a - b;
    if (c == OP_PADD) return {hi, lo};
    return a ^ b;
  endfunction

  function automatic mres_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] s);
    mres_t m;
    int r, h, l;
    m.sat = 1'b0;
    m.res = s;
    if (c == OP_ADD || c == OP_SUB) begin
      r = (c == OP_ADD) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
      if (r > 32767) begin m.res = 16'h7FFF; m.sat = 1'b1; end
      else if (r < -32768) begin m.res = 16'h8000; m.sat = 1'b1; end
      else m.res = r[15:0];
    end else if (c == OP_PADD) begin
      h = int'($signed(a[15:8])) + int'($signed(b[15:8]));
      l = int'($signed(a[7:0])) + int'($signed(b[7:0]));
      if (h > 127) begin m.res[15:8] = 8'h7F; m.sat = 1'b1; end
      else if (h < -128) begin m.res[15:8] = 8'h80; m.sat = 1'b1; end
      else m.res[15:8] = h[7:0];
      if (l > 127) begin m.res[7:0] = 8'h7F; m.sat = 1'b1; end
      else if (l < -128) begin m.res[7:0] = 8'h80; m.sat = 1'b1; end
      else m.res[7:0] = l[7:0];
    end
    return m;
  endfunction

  // Reference slot: pushes the expected result at every modelled capture.
  always @(posedge clk or negedge rst_n) begin
    logic  cap;
    mres_t m;
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_flags  = 3'b000;
      m_sticky = 1'b0;
      sb_q.delete();
    end else begin
      cap = ifc.in_valid && (!m_valid || ifc.out_ready) && !flush;
      if (flush && m_valid && !ifc.out_ready && sb_q.size() > 0)
        void'(sb_q.pop_back());
      m = model(ifc.cmd, ifc.a, ifc.b, ifc.sum);
      if (cap) begin
        sb_q.push_back({m.res, ifc.dst_in, ifc.wr_en_in, ifc.cout});
        if (ifc.flag_we && (ifc.cmd == OP_ADD || ifc.cmd == OP_SUB))
          m_flags = {m.res[15], m.sat, m.res == 16'h0000};
      end
`ifdef AU_SAT_STICKY_EN
      if (cap && m.sat) m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
`endif
      if (cap) m_valid = 1'b1;
      else if (flush || ifc.out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("out_valid", ifc.out_valid, m_valid);
      check("in_ready", ifc.in_ready, !m_valid || ifc.out_ready);
      check("flags_nvz", {flag_n, flag_v, flag_z}, m_flags);
      check("sat_sticky", sat_sticky, m_sticky);
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_result", ifc.out_result, e.res);
          check("out_dst", ifc.out_dst, e.dst);
          check("out_wr_en", ifc.out_wr_en, e.wr);
          check("out_cout", ifc.out_cout, e.cout);
        end
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                      input logic fwe, output int cycles);
    logic acc;
    logic ok;
    ifc.cmd      = c;
    ifc.a        = a;
    ifc.b        = b;
    ifc.sum      = gen_sum(c, a, b);
    ifc.cout     = 1'($urandom);
    ifc.dst_in   = 4'($urandom);
    ifc.wr_en_in = 1'($urandom);
    ifc.flag_we  = fwe;
    ifc.in_valid = 1'b1;
    ok = 1'b0;
    cycles = 0;
    for (int k = 0; k < 32 && !ok; k++) begin
      if (rnd_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
      acc = (!m_valid || ifc.out_ready) && !flush;
      @(posedge clk);
      #1;
      cycles++;
      ok = acc;
    end
    if (!ok) check("send_timeout", 0, 1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] ops[5];
  int cyc;

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_PADD; ops[3] = 4'b0011; ops[4] = 4'b1111;
    ifc.in_valid = 1'b0; ifc.cmd = OP_ADD; ifc.a = '0; ifc.b = '0; ifc.sum = '0; ifc.cout = 1'b0;
    ifc.dst_in = '0; ifc.wr_en_in = 1'b0; ifc.flag_we = 1'b0; ifc.out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_result", ifc.out_result, 0);
    check("rst_out_dst", ifc.out_dst, 0);
    check("rst_out_wr_en", ifc.out_wr_en, 0);
    check("rst_flags", {flag_n, flag_v, flag_z}, 0);
    check("rst_sticky", sat_sticky, 0);
    idle(2);
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;

    send(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, cyc);
    check("add_pos_sat", ifc.out_result, 16'h7FFF);
    check("add_pos_vnz", {flag_v, flag_n, flag_z}, 3'b100);
    check("add_pos_valid", ifc.out_valid, 1);
    send(OP_SUB, 16'h8000, 16'h0001, 1'b1, cyc);
    check("sub_neg_sat", ifc.out_result, 16'h8000);
    check("sub_neg_vn", {flag_v, flag_n}, 2'b11);
    send(OP_SUB, 16'h0005, 16'h0005, 1'b1, cyc);
    check("sub_zero", ifc.out_result, 16'h0000);
    check("sub_zero_zvn", {flag_z, flag_v, flag_n}, 3'b100);
    send(OP_PADD, 16'h7F80, 16'h01FF, 1'b1, cyc);
    check("padd_sat", ifc.out_result, 16'h7F80);
    check("padd_flags_kept", {flag_z, flag_v, flag_n}, 3'b100);
    idle(1);

    send(OP_ADD, 16'h1234, 16'h1111, 1'b1, cyc);
    ifc.out_ready = 1'b0;
    repeat (3) begin
      idle(1);
      check("stall_hold", ifc.out_result, 16'h2345);
      check("stall_in_ready", ifc.in_ready, 0);
    end
    ifc.out_ready = 1'b1;
    send(OP_ADD, 16'h0100, 16'h0200, 1'b1, cyc);
    check("b2b_cycles", cyc, 1);
    check("b2b_result", ifc.out_result, 16'h0300);
    idle(1);

    send(OP_SUB, 16'h0000, 16'h0001, 1'b1, cyc);
    idle(1);
    ifc.cmd = OP_ADD; ifc.a = 16'h0001; ifc.b = 16'hFFFF; ifc.sum = 16'h0000;
    ifc.flag_we = 1'b1; ifc.in_valid = 1'b1; flush = 1'b1;
    idle(1);
    check("flush_valid", ifc.out_valid, 0);
    check("flush_flags_kept", {flag_z, flag_n}, 2'b01);
    flush = 1'b0; ifc.in_valid = 1'b0;

    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 0) ra[14:8] = 7'h7F;
      send(ops[$urandom_range(0, 4)], ra, rb, 1'($urandom), cyc);
    end
    rnd_ready = 1'b0;
    ifc.out_ready = 1'b1;
    idle(2);

`ifdef AU_SAT_STICKY_EN
    sticky_clr = 1'b1;
    idle(1);
    sticky_clr = 1'b0;
    check("sticky_cleared", sat_sticky, 0);
    send(OP_ADD, 16'h7FFF, 16'h7FFF, 1'b0, cyc);
    check("sticky_set", sat_sticky, 1);
    sticky_clr = 1'b1;
    send(OP_SUB, 16'h8000, 16'h7FFF, 1'b0, cyc);
    sticky_clr = 1'b0;
    check("sticky_set_wins", sat_sticky, 1);
`else
    sticky_clr = 1'b1;
    send(OP_ADD, 16'h7FFF, 16'h7FFF, 1'b0, cyc);
    sticky_clr = 1'b0;
    check("sticky_tied_off", sat_sticky, 0);
`endif
    idle(1);

    send(OP_ADD, 16'h7000, 16'h7000, 1'b1, cyc);
    ifc.out_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", ifc.out_valid, 0);
    check("arst_out_result", ifc.out_result, 0);
    check("arst_out_dst", ifc.out_dst, 0);
    check("arst_out_wr_en", ifc.out_wr_en, 0);
    check("arst_flags", {flag_n, flag_v, flag_z}, 0);
    check("arst_sticky", sat_sticky, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    send(OP_SUB, 16'h0003, 16'h0007, 1'b1, cyc);
    check("post_rst_result", ifc.out_result, 16'hFFFC);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
